// File: rtl/shift_pair_pkg.sv
// Shared types for the shift pair unit.
//   shift_mode_t : shift operation applied to a register on each shift step
//   state_t      : burst sequencer states
//   count_width  : default width of the burst length input for a given register width
package shift_pair_pkg;

    typedef enum logic [1:0] {
        SHR_LOG   = 2'd0,
        SHR_ARITH = 2'd1,
        SHL_LOG   = 2'd2,
        ROR       = 2'd3
    } shift_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A full burst can shift the chained pair through all 2*WIDTH positions.
    function automatic int count_width(input int width);
        return $clog2(2 * width) + 1;
    endfunction

endpackage

// File: rtl/shift_reg_n.sv
// Single WIDTH-bit shift register with clear, parallel load and one-bit shift.
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset, clears the register
//   clear      zero the register (beats load and shift)
//   load       q <= data (beats shift)
//   shift      perform one shift step using mode
//   mode       shift operation (shift_mode_t)
//   serial_in  bit entering at the msb (SHR_LOG) or at the lsb (SHL_LOG)
//   data       parallel load value
//   q          register contents
//   lsb / msb  q[0] / q[WIDTH-1]
module shift_reg_n
    import shift_pair_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic             shift,
    input  shift_mode_t      mode,
    input  logic             serial_in,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q,
    output logic             lsb,
    output logic             msb
);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = q_r;
        case (mode)
            SHR_LOG:   shifted = {serial_in, q_r[WIDTH-1:1]};
            SHR_ARITH: shifted = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            SHL_LOG:   shifted = {q_r[WIDTH-2:0], serial_in};
            ROR:       shifted = {q_r[0], q_r[WIDTH-1:1]};
            default:   shifted = q_r;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= '0;
        end else if (clear) begin
            q_r <= '0;
        end else if (load) begin
            q_r <= data;
        end else if (shift) begin
            q_r <= shifted;
        end
    end

    assign q   = q_r;
    assign lsb = q_r[0];
    assign msb = q_r[WIDTH-1];

endmodule

// File: rtl/shift_pair_unit.sv
// Pair of shift registers A and B for the shift-add multiplier datapath, with
// chain mode ({A,B} as one 2*WIDTH register) and a burst sequencer that runs
// Count shifts after a single Start pulse.
// Ports:
//   Clk, Reset           clock and synchronous active-high reset
//   ClearA/B, LoadA/B    zero / parallel-load a register (IDLE only)
//   DataA/B              parallel load values
//   Shift_En             single shift with live Mode/Chain (IDLE only)
//   Start, Count         begin a burst of Count shifts (IDLE only)
//   Mode, Chain          shift mode (shift_mode_t) and chain select
//   A_In, B_In           serial-in bits, sampled live on every shift
//   A_Out, B_Out         A[0], B[0]
//   A, B                 register contents
//   Busy, Done           burst in progress / one-cycle end-of-burst pulse
//
// state | meaning
// IDLE  | accepts clear/load/start/single shift
// SHIFT | burst running, one shift per cycle, remaining counts down to 1
// DONE  | one cycle after last burst shift, Done high, inputs ignored
module shift_pair_unit
    import shift_pair_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(2 * WIDTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             ClearA,
    input  logic             ClearB,
    input  logic             LoadA,
    input  logic             LoadB,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    input  logic             Shift_En,
    input  logic             Start,
    input  logic [CW-1:0]    Count,
    input  logic [1:0]       Mode,
    input  logic             Chain,
    input  logic             A_In,
    input  logic             B_In,
    output logic             A_Out,
    output logic             B_Out,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done
);

    state_t           state_q;
    logic [CW-1:0]    remaining_q;
    shift_mode_t      mode_q;
    logic             chain_q;
    logic             done_q;

    logic             idle;
    logic             in_burst;
    logic             any_clear_load;
    logic             start_ok;
    logic             step_ok;
    logic             do_shift;
    shift_mode_t      eff_mode;
    logic             eff_chain;

    shift_mode_t      mode_a;
    shift_mode_t      mode_b;
    logic             sin_a;
    logic             sin_b;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             a_lsb;
    logic             a_msb;
    logic             b_lsb;
    logic             b_msb;

    assign idle     = (state_q == IDLE);
    assign in_burst = (state_q == SHIFT);

    // A clear or load on either register blocks start and single shifts on both.
    assign any_clear_load = ClearA | ClearB | LoadA | LoadB;
    assign start_ok       = idle & Start & ~any_clear_load;
    assign step_ok        = idle & Shift_En & ~Start & ~any_clear_load;
    assign do_shift       = step_ok | in_burst;

    // Bursts run on the settings captured with Start; single shifts use live ones.
    assign eff_mode  = in_burst ? mode_q : shift_mode_t'(Mode);
    assign eff_chain = in_burst ? chain_q : Chain;

    // Chain mode is realised by retargeting each register's serial input
    // (and, where needed, its mode) so the pair behaves as one 2*WIDTH register.
    always_comb begin
        mode_a = eff_mode;
        mode_b = eff_mode;
        sin_a  = A_In;
        sin_b  = B_In;
        if (eff_chain) begin
            case (eff_mode)
                SHR_LOG: begin
                    sin_b = a_lsb;
                end
                SHR_ARITH: begin
                    mode_b = SHR_LOG;
                    sin_b  = a_lsb;
                end
                ROR: begin
                    mode_a = SHR_LOG;
                    sin_a  = b_lsb;
                    mode_b = SHR_LOG;
                    sin_b  = a_lsb;
                end
                SHL_LOG: begin
                    sin_a = b_msb;
                end
                default: begin
                    mode_a = eff_mode;
                end
            endcase
        end
    end

    shift_reg_n #(.WIDTH(WIDTH)) u_reg_a (
        .clk       (Clk),
        .reset     (Reset),
        .clear     (idle & ClearA),
        .load      (idle & LoadA),
        .shift     (do_shift),
        .mode      (mode_a),
        .serial_in (sin_a),
        .data      (DataA),
        .q         (a_q),
        .lsb       (a_lsb),
        .msb       (a_msb)
    );

    shift_reg_n #(.WIDTH(WIDTH)) u_reg_b (
        .clk       (Clk),
        .reset     (Reset),
        .clear     (idle & ClearB),
        .load      (idle & LoadB),
        .shift     (do_shift),
        .mode      (mode_b),
        .serial_in (sin_b),
        .data      (DataB),
        .q         (b_q),
        .lsb       (b_lsb),
        .msb       (b_msb)
    );

    // Done is registered so a zero-length burst can pulse it without leaving IDLE.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            mode_q      <= SHR_LOG;
            chain_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        if (Count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= SHIFT;
                            remaining_q <= Count;
                            mode_q      <= shift_mode_t'(Mode);
                            chain_q     <= Chain;
                        end
                    end
                end
                SHIFT: begin
                    remaining_q <= remaining_q - 1'b1;
                    if (remaining_q == CW'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign A_Out = a_lsb;
    assign B_Out = b_lsb;
    assign Busy  = in_burst;
    assign Done  = done_q;

endmodule
